alu_bus_sequencer: RTL and testbench
====================================

Name: alu_bus_sequencer

Overview:
Host-side driver of the ALU control unit's INBUS/OUTBUS protocol. It accepts one operation request over a valid/ready interface and asserts BEGIN and op_code to the control unit. It serializes the operands onto INBUS in the exact load order each op expects, then collects the pushed A/Q words from OUTBUS. It returns a single response with a status code.

Parameters:
WIDTH, 8, data width of INBUS/OUTBUS and of each operand register
TIMEOUT_CYCLES, 255, max cycles from BEGIN to END before the operation is aborted with timeout status (minimum 4)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  2  00 add, 01 sub, 10 mul (Radix-4), 11 div (SRT-2)
req_a  in  WIDTH  dividend high word; used for div only
req_x  in  WIDTH  add/sub: A operand; mul: multiplier (Q); div: dividend low word (Q)
req_y  in  WIDTH  M operand (addend, subtrahend, multiplicand, divisor)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_a  out  WIDTH  captured A word (sum/diff, product high, remainder)
rsp_q  out  WIDTH  captured Q word (product low, quotient); 0 for add/sub
rsp_status  out  2  00 ok, 01 timeout, 10 protocol error
BEGIN  out  1  start pulse to control unit
op_code  out  2  op to control unit
inbus  out  WIDTH  INBUS drive
outbus  in  WIDTH  OUTBUS from datapath
push_a  in  1  control unit pushAregister strobe
push_q  in  1  control unit pushQregister strobe
END  in  1  control unit end strobe

Behaviour:
- Reset (reset=0 at clk edge): state IDLE. All outputs 0 except req_ready=1. Captures, flags and timeout counter cleared. Reset mid-operation discards the operation and produces no response.
- States: IDLE, LOAD0, LOAD1, LOAD2, WAIT, RESP. One-hot state register. Outputs are decoded from the current state.
- IDLE: req_ready=1. On req_valid&req_ready, latch req_op/a/x/y and go to LOAD0 next cycle.
- LOAD0: BEGIN=1 for exactly this one cycle. inbus = req_a for div, otherwise req_x. Next state is LOAD1.
- LOAD1: inbus = req_x for div, otherwise req_y. Next state is LOAD2 for div, WAIT otherwise.
- LOAD2 (div only): inbus = req_y. Next state is WAIT.
- op_code = latched op in every state from LOAD0 through WAIT; 0 in IDLE and RESP.
- inbus = 0 outside LOAD states.
- Capture rule: OUTBUS carries the pushed register in the cycle after the strobe.
  - push_a seen at cycle t: capture outbus into rsp_a at t+1.
  - push_q seen at cycle t: capture outbus into rsp_q at t+1.
  - Strobes are honoured in LOAD1..WAIT; they are ignored in IDLE/RESP.
- Expected pushes:
  - add/sub: A only.
  - mul: A then Q.
  - div: Q then A.
- Protocol error (status 10) when any of these occur:
  - a push_q arrives for add/sub;
  - a duplicate push arrives;
  - END arrives before all expected captures are scheduled.
- Completion: END seen in WAIT with all expected pushes seen. END may coincide with the final capture cycle; that capture is kept. Next state is RESP.
- Timeout: counter starts at 0 in LOAD0 and increments every cycle until RESP. When it reaches TIMEOUT_CYCLES with no END, go to RESP with status 01 and keep partial captures.
- RESP: rsp_valid=1. rsp_a, rsp_q and rsp_status are held stable until rsp_valid&rsp_ready, then go to IDLE. req_ready=0 while in RESP.
- Simultaneous error and timeout: error (10) wins. END while in IDLE/RESP is ignored.
- Latency with no backpressure: rsp_valid rises exactly 1 cycle after END.

Decomposition:
- Shared package: op codes OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11; status codes ST_OK, ST_TIMEOUT, ST_PROTO; state index constants.
- One natural sub-module: alu_result_capture. It holds the push-to-capture delay registers, the rsp_a/rsp_q capture registers, seen-A/seen-Q flags and duplicate/unexpected detection. It is cleared on accept.

Test Plan (WIDTH=8; bench models the control unit's load/push/END timing):
- add: x=25, y=17 -> BEGIN for one cycle with inbus=25, then inbus=17; model push_a; expect rsp_a=42, rsp_q=0, status 00.
- mul: x=0xFD (-3), y=0x07 -> inbus order FD,07; pushes A then Q; expect rsp_a=0xFF, rsp_q=0xEB (-21), status 00.
- div: a=0x00, x=0x64, y=0x07 -> inbus order 00,64,07 over 3 cycles; pushes Q then A; expect rsp_q=14, rsp_a=2, status 00.
- timeout with TIMEOUT_CYCLES=10: model never asserts END -> rsp_valid in the cycle after the counter reaches 10, status 01; req_ready returns only after rsp accept.
- backpressure/error: rsp_ready low 5 cycles -> rsp fields stable, req_ready=0. Separately, push_q during add -> status 10.
- reset mid-op: reset=0 during WAIT -> next cycle all outputs 0, req_ready=1, no rsp_valid; a following add (3+4) returns rsp_a=7.

Source files
------------

// File: rtl/alu_bus_sequencer_pkg.sv
// Shared encodings for the ALU bus sequencer: op codes, status codes, FSM state indices.
package alu_bus_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_PROTO   = 2'b10
    } st_e;

    localparam int unsigned NUM_STATES = 6;
    localparam int unsigned IDX_IDLE   = 0;
    localparam int unsigned IDX_LOAD0  = 1;
    localparam int unsigned IDX_LOAD1  = 2;
    localparam int unsigned IDX_LOAD2  = 3;
    localparam int unsigned IDX_WAIT   = 4;
    localparam int unsigned IDX_RESP   = 5;

    // mul and div return a Q word as well as an A word
    function automatic logic op_needs_q(op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_result_capture.sv
// Captures pushed A/Q words one cycle after their strobes and flags protocol violations.
module alu_result_capture
    import alu_bus_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             active,
    input  op_e              op,
    input  logic             push_a,
    input  logic             push_q,
    input  logic             early_end,
    input  logic [WIDTH-1:0] outbus,
    output logic [WIDTH-1:0] cap_a,
    output logic [WIDTH-1:0] cap_q,
    output logic             all_seen_c,
    output logic             err_c
);

    logic need_q;
    logic a_hit;
    logic q_hit;
    logic pend_a_q;
    logic pend_q_q;
    logic seen_a_q;
    logic seen_q_q;
    logic err_q;

    assign need_q = op_needs_q(op);
    assign a_hit  = push_a & active;
    assign q_hit  = push_q & active;

    // Sticky error plus anything detected this cycle, so a same-cycle END sees it
    assign err_c = err_q
                 | (a_hit & seen_a_q)
                 | (q_hit & seen_q_q)
                 | (q_hit & ~need_q)
                 | early_end;

    assign all_seen_c = seen_a_q & (seen_q_q | ~need_q);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            pend_a_q <= 1'b0;
            pend_q_q <= 1'b0;
            seen_a_q <= 1'b0;
            seen_q_q <= 1'b0;
            err_q    <= 1'b0;
            cap_a    <= '0;
            cap_q    <= '0;
        end else begin
            pend_a_q <= a_hit;
            pend_q_q <= q_hit & need_q;
            seen_a_q <= seen_a_q | a_hit;
            seen_q_q <= seen_q_q | (q_hit & need_q);
            err_q    <= err_c;
            // Captures are dropped once the response is being presented
            if (pend_a_q && active) begin
                cap_a <= outbus;
            end
            if (pend_q_q && active) begin
                cap_q <= outbus;
            end
        end
    end

endmodule

// File: rtl/alu_bus_sequencer.sv
// Host-side driver of the ALU control unit INBUS/OUTBUS protocol: request in, operands
// serialized onto INBUS, pushed A/Q words collected from OUTBUS, one response out.
module alu_bus_sequencer
    import alu_bus_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_a,
    output logic [WIDTH-1:0] rsp_q,
    output logic [1:0]       rsp_status,
    output logic             BEGIN,
    output logic [1:0]       op_code,
    output logic [WIDTH-1:0] inbus,
    input  logic [WIDTH-1:0] outbus,
    input  logic             push_a,
    input  logic             push_q,
    input  logic             END
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [NUM_STATES-1:0] S_IDLE  = 6'b000001;
    localparam logic [NUM_STATES-1:0] S_LOAD0 = 6'b000010;
    localparam logic [NUM_STATES-1:0] S_LOAD1 = 6'b000100;
    localparam logic [NUM_STATES-1:0] S_LOAD2 = 6'b001000;
    localparam logic [NUM_STATES-1:0] S_WAIT  = 6'b010000;
    localparam logic [NUM_STATES-1:0] S_RESP  = 6'b100000;

    logic [NUM_STATES-1:0] state_q;
    logic [NUM_STATES-1:0] state_d;
    op_e                   op_q;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      x_q;
    logic [WIDTH-1:0]      y_q;
    logic [CNT_W-1:0]      cnt_q;
    st_e                   status_q;
    st_e                   status_d;

    logic accept;
    logic in_wait;
    logic active;
    logic in_op;
    logic timeout_hit;
    logic early_end_c;
    logic all_seen_c;
    logic err_c;

    assign accept      = state_q[IDX_IDLE] & req_valid;
    assign in_wait     = state_q[IDX_WAIT];
    assign active      = state_q[IDX_LOAD1] | state_q[IDX_LOAD2] | in_wait;
    assign in_op       = state_q[IDX_LOAD0] | active;
    assign timeout_hit = in_wait & (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    // END anywhere in the operation before every expected push was scheduled
    assign early_end_c = END & in_op & ~(in_wait & all_seen_c);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d  = S_LOAD0;
                    status_d = ST_OK;
                end
            end
            S_LOAD0: state_d = S_LOAD1;
            S_LOAD1: state_d = (op_q == OP_DIV) ? S_LOAD2 : S_WAIT;
            S_LOAD2: state_d = S_WAIT;
            S_WAIT: begin
                if (END || timeout_hit) begin
                    state_d = S_RESP;
                    if (err_c) begin
                        status_d = ST_PROTO;
                    end else if (END) begin
                        status_d = ST_OK;
                    end else begin
                        status_d = ST_TIMEOUT;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, timeout counter and response status
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            status_q <= ST_OK;
        end else begin
            status_q <= status_d;
            if (accept) begin
                op_q  <= op_e'(req_op);
                a_q   <= req_a;
                x_q   <= req_x;
                y_q   <= req_y;
                cnt_q <= '0;
            end else if (in_op) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    alu_result_capture #(
        .WIDTH(WIDTH)
    ) u_capture (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .active    (active),
        .op        (op_q),
        .push_a    (push_a),
        .push_q    (push_q),
        .early_end (early_end_c),
        .outbus    (outbus),
        .cap_a     (rsp_a),
        .cap_q     (rsp_q),
        .all_seen_c(all_seen_c),
        .err_c     (err_c)
    );

    assign req_ready  = state_q[IDX_IDLE];
    assign rsp_valid  = state_q[IDX_RESP];
    assign BEGIN      = state_q[IDX_LOAD0];
    assign op_code    = in_op ? op_q : OP_ADD;
    assign rsp_status = status_q;

    // Operand load order: div sends A, Q, M; the others send A/Q then M
    always_comb begin
        inbus = '0;
        if (state_q[IDX_LOAD0]) begin
            inbus = (op_q == OP_DIV) ? a_q : x_q;
        end else if (state_q[IDX_LOAD1]) begin
            inbus = (op_q == OP_DIV) ? x_q : y_q;
        end else if (state_q[IDX_LOAD2]) begin
            inbus = y_q;
        end
    end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Bench for alu_bus_sequencer: models the control unit's push/END timing from a per-op schedule.
module tb_alu_bus_sequencer;

    localparam int unsigned W = 8;
    localparam int unsigned T = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_x;
    logic [W-1:0] req_y;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_a;
    logic [W-1:0] rsp_q;
    logic [1:0]   rsp_status;
    logic         BEGIN;
    logic [1:0]   op_code;
    logic [W-1:0] inbus;
    logic [W-1:0] outbus;
    logic         push_a;
    logic         push_q;
    logic         END;

    alu_bus_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_a     (rsp_a),
        .rsp_q     (rsp_q),
        .rsp_status(rsp_status),
        .BEGIN     (BEGIN),
        .op_code   (op_code),
        .inbus     (inbus),
        .outbus    (outbus),
        .push_a    (push_a),
        .push_q    (push_q),
        .END       (END)
    );

    always #5 clk = ~clk;

    // Schedule offsets count cycles from the BEGIN cycle (k=0); -1 means never
    typedef struct {
        int         op;
        logic [7:0] a;
        logic [7:0] x;
        logic [7:0] y;
        int         pa;
        int         pa2;
        int         pq;
        int         pe;
        int         bp;
        logic [7:0] ea;
        logic [7:0] eq;
        logic [1:0] es;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl [10];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int op, logic [7:0] a, logic [7:0] x, logic [7:0] y,
                                int pa, int pa2, int pq, int pe, int bp,
                                logic [7:0] ea, logic [7:0] eq, logic [1:0] es);
        vec_t r;
        r.op = op; r.a = a; r.x = x; r.y = y;
        r.pa = pa; r.pa2 = pa2; r.pq = pq; r.pe = pe; r.bp = bp;
        r.ea = ea; r.eq = eq; r.es = es;
        return r;
    endfunction

    // Datapath result {A, Q}: mul is signed, div is unsigned {a,x}/y
    function automatic logic [15:0] alu_model(int op, logic [7:0] a, logic [7:0] x, logic [7:0] y);
        int          p;
        logic [15:0] d;
        logic [15:0] qt;
        logic [15:0] rm;
        case (op)
            0:       return {8'(x + y), 8'h00};
            1:       return {8'(x - y), 8'h00};
            2: begin
                p = int'($signed(x)) * int'($signed(y));
                return p[15:0];
            end
            default: begin
                d  = {a, x};
                qt = d / 16'(y);
                rm = d % 16'(y);
                return {rm[7:0], qt[7:0]};
            end
        endcase
    endfunction

    // Outcome from the schedule: which END/timeout ends the op, what got captured, which rule broke
    function automatic vec_t predict(input vec_t vi);
        vec_t        r;
        logic [15:0] dp;
        bit          fin;
        bit          mq;
        bit          err;
        int          kf;
        r   = vi;
        dp  = alu_model(vi.op, vi.a, vi.x, vi.y);
        mq  = (vi.op >= 2);
        fin = (vi.pe >= 0) && (vi.pe <= int'(T));
        kf  = fin ? vi.pe : int'(T);
        err = !mq && vi.pq >= 1 && vi.pq <= kf;
        if (fin && !(vi.pa >= 1 && vi.pa < kf)) err = 1'b1;
        if (fin && mq && !(vi.pq >= 1 && vi.pq < kf)) err = 1'b1;
        r.ea = (vi.pa >= 1 && vi.pa + 1 <= kf) ? dp[15:8] : 8'h00;
        r.eq = (mq && vi.pq >= 1 && vi.pq + 1 <= kf) ? dp[7:0] : 8'h00;
        r.es = err ? 2'b10 : (fin ? 2'b00 : 2'b01);
        return r;
    endfunction

    task automatic run_vec(input vec_t vi, input string tag);
        logic [15:0] dp;
        logic [7:0]  ld [3];
        int          nl;
        int          got_k;
        int          exp_k;
        int          w;
        dp = alu_model(vi.op, vi.a, vi.x, vi.y);
        if (vi.op == 3) begin
            ld[0] = vi.a; ld[1] = vi.x; ld[2] = vi.y; nl = 3;
        end else begin
            ld[0] = vi.x; ld[1] = vi.y; ld[2] = 8'h00; nl = 2;
        end
        exp_k = ((vi.pe >= 0 && vi.pe <= int'(T)) ? vi.pe : int'(T)) + 1;
        w = 0;
        while (!req_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check({tag, " req_ready idle"}, 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_op    = vi.op[1:0];
        req_a     = vi.a;
        req_x     = vi.x;
        req_y     = vi.y;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " BEGIN"}, 32'(BEGIN), 32'(1));
        check({tag, " op_code"}, 32'(op_code), 32'(vi.op[1:0]));
        got_k = -1;
        for (int k = 0; k <= exp_k + 3; k++) begin
            if (rsp_valid) begin
                got_k = k;
                break;
            end
            if (k < nl) check({tag, " inbus"}, 32'(inbus), 32'(ld[k]));
            if (k == 1) begin
                check({tag, " BEGIN one cycle"}, 32'(BEGIN), 32'(0));
                check({tag, " req_ready busy"}, 32'(req_ready), 32'(0));
            end
            push_a = (k == vi.pa) || (k == vi.pa2);
            push_q = (k == vi.pq);
            END    = (k == vi.pe);
            if ((vi.pa >= 0 && k == vi.pa + 1) || (vi.pa2 >= 0 && k == vi.pa2 + 1))
                outbus = dp[15:8];
            else if (vi.pq >= 0 && k == vi.pq + 1)
                outbus = dp[7:0];
            else
                outbus = 8'($urandom);
            @(posedge clk); #1;
        end
        push_a = 1'b0;
        push_q = 1'b0;
        END    = 1'b0;
        outbus = 8'h00;
        check({tag, " rsp latency"}, 32'(got_k), 32'(exp_k));
        for (int i = 0; i <= vi.bp; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1));
            check({tag, " rsp_a"}, 32'(rsp_a), 32'(vi.ea));
            check({tag, " rsp_q"}, 32'(rsp_q), 32'(vi.eq));
            check({tag, " rsp_status"}, 32'(rsp_status), 32'(vi.es));
            check({tag, " req_ready in resp"}, 32'(req_ready), 32'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " rsp_valid after accept"}, 32'(rsp_valid), 32'(0));
        check({tag, " req_ready after accept"}, 32'(req_ready), 32'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ready"}, 32'(req_ready), 32'(1));
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(0));
        check({tag, " BEGIN"}, 32'(BEGIN), 32'(0));
        check({tag, " op_code"}, 32'(op_code), 32'(0));
        check({tag, " inbus"}, 32'(inbus), 32'(0));
        check({tag, " rsp_a"}, 32'(rsp_a), 32'(0));
        check({tag, " rsp_q"}, 32'(rsp_q), 32'(0));
        check({tag, " rsp_status"}, 32'(rsp_status), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        // op, a, x, y, pa, pa2, pq, pe, bp, exp_a, exp_q, exp_status
        tbl[0] = mk(0, 8'h00, 8'd25, 8'd17, 2, -1, -1, 4, 5, 8'd42, 8'h00, 2'b00);
        tbl[1] = mk(2, 8'h00, 8'hFD, 8'h07, 2, -1, 3, 5, 0, 8'hFF, 8'hEB, 2'b00);
        tbl[2] = mk(3, 8'h00, 8'h64, 8'h07, 4, -1, 3, 5, 0, 8'h02, 8'h0E, 2'b00);
        tbl[3] = mk(0, 8'h00, 8'h01, 8'h02, 2, -1, -1, -1, 0, 8'h03, 8'h00, 2'b01);
        tbl[4] = mk(1, 8'h00, 8'h05, 8'h09, 2, -1, -1, 3, 0, 8'hFC, 8'h00, 2'b00);
        tbl[5] = mk(0, 8'h00, 8'h01, 8'h01, 2, -1, 3, 5, 0, 8'h02, 8'h00, 2'b10);
        tbl[6] = mk(2, 8'h00, 8'h02, 8'h03, 2, -1, 4, 4, 0, 8'h00, 8'h00, 2'b10);
        tbl[7] = mk(2, 8'h00, 8'h40, 8'h10, 2, -1, -1, -1, 0, 8'h04, 8'h00, 2'b01);
        tbl[8] = mk(0, 8'h00, 8'h05, 8'h06, 2, -1, -1, 10, 0, 8'h0B, 8'h00, 2'b00);
        tbl[9] = mk(0, 8'h00, 8'h10, 8'h20, 2, 3, -1, 5, 0, 8'h30, 8'h00, 2'b10);

        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = 8'h00;
        req_x     = 8'h00;
        req_y     = 8'h00;
        rsp_ready = 1'b0;
        outbus    = 8'h00;
        push_a    = 1'b0;
        push_q    = 1'b0;
        END       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while waiting for END: operation is dropped without a response
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_x     = 8'd9;
        req_y     = 8'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        push_a = 1'b1;
        @(posedge clk); #1;
        push_a = 1'b0;
        outbus = 8'd18;
        reset  = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b1;
        outbus = 8'h00;
        check_idle_outputs("midreset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midreset no rsp", 32'(rsp_valid), 32'(0));
        end
        run_vec(mk(0, 8'h00, 8'd3, 8'd4, 2, -1, -1, 3, 0, 8'd7, 8'h00, 2'b00), "post_reset");

        for (int i = 0; i < 40; i++) begin
            int ws;
            v.op  = int'($urandom_range(0, 3));
            v.a   = 8'($urandom);
            v.x   = 8'($urandom);
            v.y   = (v.op == 3) ? 8'($urandom_range(1, 255)) : 8'($urandom);
            ws    = (v.op == 3) ? 3 : 2;
            v.pa  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 6));
            v.pa2 = -1;
            if (v.op >= 2) begin
                if ($urandom_range(0, 9) == 0) begin
                    v.pq = -1;
                end else begin
                    v.pq = int'($urandom_range(1, 6));
                    if (v.pq == v.pa) v.pq = v.pa + 1;
                end
            end else begin
                v.pq = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
                if (v.pq == v.pa) v.pq = -1;
            end
            v.pe = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(ws, 11));
            v.bp = int'($urandom_range(0, 2));
            v    = predict(v);
            run_vec(v, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
